// File: rtl/sdram_tester_pkg.sv
// sdram_tester_pkg
//   Shared definitions for the SDRAM traffic generator/checker:
//   - state_t      : tester FSM states
//   - SEED_DEFAULT : default XOR constant applied to the data pattern
//   - pat()        : folds an address into one byte (XOR of all 8-bit chunks,
//                    top chunk zero-padded) and XORs in the seed
package sdram_tester_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ISSUE,
    ST_WR_WAIT,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_DONE,
    ST_FAIL
  } state_t;

  localparam logic [7:0] SEED_DEFAULT = 8'hA5;

  // Widest address pat() can fold. Narrower addresses are zero-extended by
  // the caller, which is exactly the zero-padding of the top chunk.
  localparam int PAT_MAX_W = 64;

  function automatic logic [7:0] pat(input logic [PAT_MAX_W-1:0] addr,
                                     input logic [7:0]           seed);
    logic [7:0] acc;
    acc = seed;
    for (int i = 0; i < PAT_MAX_W / 8; i++) begin
      acc = acc ^ addr[i*8 +: 8];
    end
    return acc;
  endfunction

endpackage

// File: rtl/sdram_pattern_gen.sv
// sdram_pattern_gen
//   Combinational test-pattern generator shared by the write path and the
//   read checker, so both always agree on the expected byte.
//   Ports:
//     addr    in  ADDR_W  array address being written/checked
//     pass    in  1       0 = true pattern, 1 = complemented pattern
//     pattern out 8       data byte for (addr, pass)
module sdram_pattern_gen
  import sdram_tester_pkg::*;
#(
  parameter int         ADDR_W = 26,
  parameter logic [7:0] SEED   = SEED_DEFAULT
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              pass,
  output logic [7:0]        pattern
);

  logic [7:0] base;

  assign base    = pat(PAT_MAX_W'(addr), SEED);
  assign pattern = pass ? ~base : base;

endmodule

// File: rtl/sdram_tester.sv
// sdram_tester
//   Traffic generator and checker sitting upstream of the SDRAM controller.
//   Runs two passes over addresses 0..ADDR_LAST: each pass writes every
//   address, then reads every address back and compares. Pass 0 uses the
//   true pattern, pass 1 the complemented one. Status is sticky until the
//   next start.
//   Ports:
//     clk, resetn          clock, asynchronous active-low reset
//     start                level, honoured only in IDLE/DONE/FAIL
//     sdram_rd/sdram_wr    one-cycle command strobes to the controller
//     sdram_addr/din       command address / write data, held while waiting
//     sdram_dout           read data, valid with sdram_data_ready
//     sdram_busy           controller busy
//     sdram_data_ready     one-cycle read-data strobe
//     sdram_refresh        refresh enable, high whenever the tester is idle
//     running              high while a test run is in progress
//     done/fail/timeout    sticky run status
//     err_count            saturating mismatch count
//     first_err_*          address / expected / received data of first miss
module sdram_tester
  import sdram_tester_pkg::*;
#(
  parameter int                ADDR_W      = 26,
  parameter logic [ADDR_W-1:0] ADDR_LAST   = {ADDR_W{1'b1}},
  parameter logic [7:0]        SEED        = SEED_DEFAULT,
  parameter int                TIMEOUT     = 1023,
  parameter bit                STOP_ON_ERR = 1'b0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  output logic              sdram_rd,
  output logic              sdram_wr,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [7:0]        sdram_din,
  input  logic [7:0]        sdram_dout,
  input  logic              sdram_busy,
  input  logic              sdram_data_ready,
  output logic              sdram_refresh,
  output logic              running,
  output logic              done,
  output logic              fail,
  output logic              timeout,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [7:0]        first_err_exp,
  output logic [7:0]        first_err_got
);

  localparam int              TW         = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT - 1);

  state_t            state_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              pass_reg;
  logic [TW-1:0]     timer_reg;
  logic              wait_first_reg;

  logic [7:0]        pattern;
  logic              mismatch;

  sdram_pattern_gen #(
    .ADDR_W (ADDR_W),
    .SEED   (SEED)
  ) u_pattern_gen (
    .addr    (addr_reg),
    .pass    (pass_reg),
    .pattern (pattern)
  );

  // addr_reg/pass_reg are held through RD_WAIT, so pattern is the expected
  // byte for the read in flight.
  assign mismatch = (sdram_dout != pattern);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= ST_IDLE;
      addr_reg       <= '0;
      pass_reg       <= 1'b0;
      timer_reg      <= '0;
      wait_first_reg <= 1'b0;
      sdram_rd       <= 1'b0;
      sdram_wr       <= 1'b0;
      sdram_addr     <= '0;
      sdram_din      <= '0;
      sdram_refresh  <= 1'b1;
      running        <= 1'b0;
      done           <= 1'b0;
      fail           <= 1'b0;
      timeout        <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      first_err_exp  <= '0;
      first_err_got  <= '0;
    end else begin
      // Strobes are single-cycle; only an ISSUE state raises them again.
      sdram_rd <= 1'b0;
      sdram_wr <= 1'b0;

      case (state_reg)
        ST_IDLE, ST_DONE, ST_FAIL: begin
          if (start) begin
            state_reg      <= ST_WR_ISSUE;
            addr_reg       <= '0;
            pass_reg       <= 1'b0;
            done           <= 1'b0;
            fail           <= 1'b0;
            timeout        <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_exp  <= '0;
            first_err_got  <= '0;
            running        <= 1'b1;
            sdram_refresh  <= 1'b0;
          end
        end

        ST_WR_ISSUE: begin
          if (!sdram_busy) begin
            sdram_wr       <= 1'b1;
            sdram_addr     <= addr_reg;
            sdram_din      <= pattern;
            timer_reg      <= '0;
            wait_first_reg <= 1'b1;
            state_reg      <= ST_WR_WAIT;
          end
        end

        ST_WR_WAIT: begin
          wait_first_reg <= 1'b0;
          // busy is stale in the first WAIT cycle (controller has not yet
          // seen the strobe), so it cannot signal completion there.
          if (!wait_first_reg && !sdram_busy) begin
            if (addr_reg == ADDR_LAST) begin
              addr_reg  <= '0;
              state_reg <= ST_RD_ISSUE;
            end else begin
              addr_reg  <= addr_reg + 1'b1;
              state_reg <= ST_WR_ISSUE;
            end
          end else if (timer_reg == TIMER_LAST) begin
            timeout       <= 1'b1;
            fail          <= 1'b1;
            running       <= 1'b0;
            sdram_refresh <= 1'b1;
            state_reg     <= ST_FAIL;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end

        ST_RD_ISSUE: begin
          if (!sdram_busy) begin
            sdram_rd   <= 1'b1;
            sdram_addr <= addr_reg;
            timer_reg  <= '0;
            state_reg  <= ST_RD_WAIT;
          end
        end

        ST_RD_WAIT: begin
          if (sdram_data_ready) begin
            if (mismatch) begin
              if (err_count != 16'hFFFF) begin
                err_count <= err_count + 1'b1;
              end
              if (err_count == 16'd0) begin
                first_err_addr <= addr_reg;
                first_err_exp  <= pattern;
                first_err_got  <= sdram_dout;
              end
            end

            if (mismatch && STOP_ON_ERR) begin
              fail          <= 1'b1;
              running       <= 1'b0;
              sdram_refresh <= 1'b1;
              state_reg     <= ST_FAIL;
            end else if (addr_reg != ADDR_LAST) begin
              addr_reg  <= addr_reg + 1'b1;
              state_reg <= ST_RD_ISSUE;
            end else if (!pass_reg) begin
              pass_reg  <= 1'b1;
              addr_reg  <= '0;
              state_reg <= ST_WR_ISSUE;
            end else begin
              // err_count has not absorbed this cycle's miss yet.
              done          <= 1'b1;
              fail          <= (err_count != 16'd0) || mismatch;
              running       <= 1'b0;
              sdram_refresh <= 1'b1;
              state_reg     <= ST_DONE;
            end
          end else if (timer_reg == TIMER_LAST) begin
            timeout       <= 1'b1;
            fail          <= 1'b1;
            running       <= 1'b0;
            sdram_refresh <= 1'b1;
            state_reg     <= ST_FAIL;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_tester.sv
// tb_sdram_tester
//   Three tester instances share one clock/reset, each driving its own
//   behavioural controller model:
//     0: ADDR_LAST=15, STOP_ON_ERR=0, TIMEOUT=64 (main runs, reset, timeout)
//     1: ADDR_LAST=15, STOP_ON_ERR=1, TIMEOUT=64 (stop on first error)
//     2: ADDR_LAST=0 with spurious data_ready during writes
module tb_sdram_tester;

  localparam int AW = 12;
  localparam int N  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start   [N];
  logic          rd      [N];
  logic          wr      [N];
  logic [AW-1:0] addr    [N];
  logic [7:0]    din     [N];
  logic [7:0]    dout    [N];
  logic          busy    [N];
  logic          ready   [N];
  logic          refresh [N];
  logic          running [N];
  logic          done    [N];
  logic          fail    [N];
  logic          timeout [N];
  logic [15:0]   errc    [N];
  logic [AW-1:0] fea     [N];
  logic [7:0]    fee     [N];
  logic [7:0]    feg     [N];

  sdram_tester #(.ADDR_W(AW), .ADDR_LAST(12'd15), .TIMEOUT(64), .STOP_ON_ERR(1'b0)) dut0 (
    .clk(clk), .resetn(rst_n), .start(start[0]),
    .sdram_rd(rd[0]), .sdram_wr(wr[0]), .sdram_addr(addr[0]), .sdram_din(din[0]),
    .sdram_dout(dout[0]), .sdram_busy(busy[0]), .sdram_data_ready(ready[0]),
    .sdram_refresh(refresh[0]), .running(running[0]), .done(done[0]), .fail(fail[0]),
    .timeout(timeout[0]), .err_count(errc[0]), .first_err_addr(fea[0]),
    .first_err_exp(fee[0]), .first_err_got(feg[0]));

  sdram_tester #(.ADDR_W(AW), .ADDR_LAST(12'd15), .TIMEOUT(64), .STOP_ON_ERR(1'b1)) dut1 (
    .clk(clk), .resetn(rst_n), .start(start[1]),
    .sdram_rd(rd[1]), .sdram_wr(wr[1]), .sdram_addr(addr[1]), .sdram_din(din[1]),
    .sdram_dout(dout[1]), .sdram_busy(busy[1]), .sdram_data_ready(ready[1]),
    .sdram_refresh(refresh[1]), .running(running[1]), .done(done[1]), .fail(fail[1]),
    .timeout(timeout[1]), .err_count(errc[1]), .first_err_addr(fea[1]),
    .first_err_exp(fee[1]), .first_err_got(feg[1]));

  sdram_tester #(.ADDR_W(AW), .ADDR_LAST(12'd0)) dut2 (
    .clk(clk), .resetn(rst_n), .start(start[2]),
    .sdram_rd(rd[2]), .sdram_wr(wr[2]), .sdram_addr(addr[2]), .sdram_din(din[2]),
    .sdram_dout(dout[2]), .sdram_busy(busy[2]), .sdram_data_ready(ready[2]),
    .sdram_refresh(refresh[2]), .running(running[2]), .done(done[2]), .fail(fail[2]),
    .timeout(timeout[2]), .err_count(errc[2]), .first_err_addr(fea[2]),
    .first_err_exp(fee[2]), .first_err_got(feg[2]));

  // ---------------- behavioural controller models ----------------
  int         flip_idx  [N];   // read number (pass*16+addr) to corrupt, -1 none
  logic [7:0] flip_mask [N];
  logic       no_ready  [N];
  logic       spur      [N];   // spurious data_ready after each write strobe

  logic [7:0] mem [N][16];
  int         bcnt [N];
  int         dcnt [N];
  int         rd_idx [N];
  logic       cur_flip [N];
  logic       corrupt [N];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        busy[i] <= 1'b0; ready[i] <= 1'b0; dout[i] <= 8'h00; corrupt[i] <= 1'b0;
        cur_flip[i] <= 1'b0; bcnt[i] <= 0; dcnt[i] <= 0; rd_idx[i] <= 0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        ready[i]   <= 1'b0;
        corrupt[i] <= 1'b0;
        if (start[i] && !running[i]) rd_idx[i] <= 0;
        if (wr[i]) begin
          mem[i][addr[i][3:0]] <= din[i];
          busy[i] <= 1'b1;
          bcnt[i] <= 2;
          if (spur[i]) begin
            ready[i] <= 1'b1;
            dout[i]  <= 8'h00;
          end
        end else if (rd[i]) begin
          busy[i]     <= 1'b1;
          dcnt[i]     <= 3;
          cur_flip[i] <= (rd_idx[i] == flip_idx[i]);
          rd_idx[i]   <= rd_idx[i] + 1;
        end else begin
          if (bcnt[i] == 1) busy[i] <= 1'b0;
          if (bcnt[i] != 0) bcnt[i] <= bcnt[i] - 1;
          if (dcnt[i] == 1) begin
            busy[i] <= 1'b0;
            if (!no_ready[i]) begin
              ready[i]   <= 1'b1;
              dout[i]    <= mem[i][addr[i][3:0]] ^ (cur_flip[i] ? flip_mask[i] : 8'h00);
              corrupt[i] <= cur_flip[i];
            end
          end
          if (dcnt[i] != 0) dcnt[i] <= dcnt[i] - 1;
        end
      end
    end
  end

  // ---------------- checking helpers ----------------
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, exp);
    end
  endtask

  // Independent reference pattern for AW=12, seed A5.
  function automatic logic [7:0] tb_pat(input logic [AW-1:0] a, input int p);
    logic [7:0] r;
    r = a[7:0] ^ {4'b0000, a[11:8]} ^ 8'hA5;
    return (p != 0) ? ~r : r;
  endfunction

  // ---------------- scoreboard on instance 0 strobes ----------------
  typedef struct packed {
    logic          is_wr;
    logic [AW-1:0] a;
    logic [7:0]    d;
  } op_t;

  op_t sb[$];
  op_t sb_e;
  bit  sb_en = 1'b0;
  int  wr_cnt, rd_cnt, ops1, ops2;

  always @(negedge clk) begin
    if (sb_en && (wr[0] || rd[0])) begin
      checks++;
      if (wr[0]) wr_cnt++;
      if (rd[0]) rd_cnt++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_extra got wr=%0b rd=%0b addr=%0d want no op", wr[0], rd[0], addr[0]);
      end else begin
        sb_e = sb.pop_front();
        if (wr[0] === sb_e.is_wr && rd[0] === !sb_e.is_wr && addr[0] === sb_e.a &&
            (!sb_e.is_wr || din[0] === sb_e.d))
          $display("op %s addr=%0d din=%h ok", sb_e.is_wr ? "W" : "R", addr[0], din[0]);
        else begin
          failures++;
          $display("FAIL sb_op got wr=%0b rd=%0b addr=%0d din=%h want wr=%0b addr=%0d din=%h",
                   wr[0], rd[0], addr[0], din[0], sb_e.is_wr, sb_e.a, sb_e.d);
        end
      end
    end
    if (wr[1] || rd[1]) ops1++;
    if (wr[2] || rd[2]) ops2++;
  end

  // ---------------- vector table ----------------
  typedef struct {
    int            flip;
    logic [7:0]    mask;
    bit            hold;
    logic          exp_fail;
    logic [15:0]   exp_err;
    logic [AW-1:0] exp_addr;
    logic [7:0]    exp_e;
    logic [7:0]    exp_g;
  } vec_t;

  vec_t vecs [4];

  task automatic start_run(input int i, input bit hold);
    @(negedge clk);
    start[i] = 1'b1;
    @(negedge clk);
    if (hold) repeat (100) @(negedge clk);
    start[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i, input string name);
    int n;
    n = 0;
    while (running[i] && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk(name, n < 4000, 1);
  endtask

  task automatic run_vec(input int v);
    op_t o;
    flip_idx[0]  = vecs[v].flip;
    flip_mask[0] = vecs[v].mask;
    sb.delete();
    wr_cnt = 0;
    rd_cnt = 0;
    for (int p = 0; p < 2; p++) begin
      for (int a = 0; a < 16; a++) begin
        o.is_wr = 1'b1; o.a = AW'(a); o.d = tb_pat(AW'(a), p);
        sb.push_back(o);
      end
      for (int a = 0; a < 16; a++) begin
        o.is_wr = 1'b0; o.a = AW'(a); o.d = 8'h00;
        sb.push_back(o);
      end
    end
    sb_en = 1'b1;
    start_run(0, vecs[v].hold);
    wait_idle(0, "run_bound");
    sb_en = 1'b0;
    chk("done",      done[0],    1);
    chk("fail",      fail[0],    vecs[v].exp_fail);
    chk("timeout",   timeout[0], 0);
    chk("refresh",   refresh[0], 1);
    chk("err_count", errc[0],    vecs[v].exp_err);
    chk("first_addr", fea[0],    vecs[v].exp_addr);
    chk("first_exp", fee[0],     vecs[v].exp_e);
    chk("first_got", feg[0],     vecs[v].exp_g);
    chk("wr_cnt",    wr_cnt,     32);
    chk("rd_cnt",    rd_cnt,     32);
    chk("sb_left",   sb.size(),  0);
    $display("vector %0d flip=%0d done=%0b fail=%0b err=%0d first=%0d/%h/%h",
             v, vecs[v].flip, done[0], fail[0], errc[0], fea[0], fee[0], feg[0]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int mark;

    vecs[0] = '{-1, 8'h00, 1'b0, 1'b0, 16'd0, 12'd0,  8'h00, 8'h00};
    vecs[1] = '{ 7, 8'h01, 1'b0, 1'b1, 16'd1, 12'd7,  8'hA2, 8'hA3};
    vecs[2] = '{-1, 8'h00, 1'b1, 1'b0, 16'd0, 12'd0,  8'h00, 8'h00};
    vecs[3] = '{31, 8'h80, 1'b0, 1'b1, 16'd1, 12'd15, 8'h55, 8'hD5};

    for (int i = 0; i < N; i++) begin
      start[i] = 1'b0; flip_idx[i] = -1; flip_mask[i] = 8'h00;
      no_ready[i] = 1'b0; spur[i] = 1'b0;
    end
    spur[2] = 1'b1;

    // Reset state
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_wr",      wr[0],      0);
    chk("rst_rd",      rd[0],      0);
    chk("rst_refresh", refresh[0], 1);
    chk("rst_running", running[0], 0);
    chk("rst_done",    done[0],    0);
    chk("rst_fail",    fail[0],    0);
    chk("rst_errc",    errc[0],    0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven full runs on instance 0
    for (int v = 0; v < 4; v++) run_vec(v);

    // STOP_ON_ERR on instance 1: corrupt read of addr 3 in pass 0
    flip_idx[1] = 3; flip_mask[1] = 8'h01; ops1 = 0;
    start_run(1, 1'b0);
    n = 0;
    while (!(ready[1] && corrupt[1]) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("stop_find", n < 2000, 1);
    @(negedge clk);
    chk("stop_fail",    fail[1],    1);
    chk("stop_running", running[1], 0);
    chk("stop_refresh", refresh[1], 1);
    chk("stop_done",    done[1],    0);
    chk("stop_errc",    errc[1],    1);
    chk("stop_addr",    fea[1],     3);
    chk("stop_exp",     fee[1],     8'hA6);
    chk("stop_got",     feg[1],     8'hA7);
    repeat (50) @(negedge clk);
    chk("stop_ops", ops1, 20);
    $display("stop test fail=%0b err=%0d ops=%0d", fail[1], errc[1], ops1);

    // ADDR_LAST=0 on instance 2, spurious data_ready during writes
    ops2 = 0;
    start_run(2, 1'b0);
    wait_idle(2, "a0_bound");
    chk("a0_done", done[2], 1);
    chk("a0_fail", fail[2], 0);
    chk("a0_errc", errc[2], 0);
    chk("a0_ops",  ops2,    4);
    $display("addr_last0 done=%0b err=%0d ops=%0d", done[2], errc[2], ops2);

    // Reset mid-run during WR_WAIT at addr 9 (instance 1 still holds FAIL status)
    flip_idx[0] = -1;
    start_run(0, 1'b0);
    n = 0;
    while (!(wr[0] && addr[0] == 12'd9) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("mid_find", n < 2000, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_wr",       wr[0],      0);
    chk("mid_running",  running[0], 0);
    chk("mid_addr",     addr[0],    0);
    chk("mid_din",      din[0],     0);
    chk("mid_refresh",  refresh[0], 1);
    chk("mid_fail1",    fail[1],    0);
    chk("mid_errc1",    errc[1],    0);
    chk("mid_fea1",     fea[1],     0);
    chk("mid_fee1",     fee[1],     0);
    chk("mid_feg1",     feg[1],     0);
    chk("mid_done2",    done[2],    0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("mid_no_restart", running[0], 0);
    $display("reset mid-run running=%0b wr=%0b", running[0], wr[0]);
    run_vec(0);

    // Timeout: data_ready never arrives, TIMEOUT=64
    no_ready[0] = 1'b1;
    start_run(0, 1'b0);
    n = 0;
    while (!rd[0] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("to_find", n < 2000, 1);
    mark = 0;
    while (!timeout[0] && mark < 200) begin
      @(negedge clk);
      mark++;
    end
    chk("to_latency", mark,       64);
    chk("to_fail",    fail[0],    1);
    chk("to_done",    done[0],    0);
    chk("to_running", running[0], 0);
    chk("to_refresh", refresh[0], 1);
    $display("timeout after %0d cycles fail=%0b", mark, fail[0]);
    no_ready[0] = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
